// File: rtl/score_pkg.sv
// Shared types and constants for the BCD score sequencer.
package score_pkg;

    // One BCD digit.
    typedef logic [3:0] bcd_digit_t;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ADD    = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // Round-robin pointer encoding.
    localparam logic RR_CLR  = 1'b0;
    localparam logic RR_DROP = 1'b1;

    // Line-clear award table, as two BCD digits.
    localparam logic [7:0] CLR_AWARD_1 = 8'h01;
    localparam logic [7:0] CLR_AWARD_2 = 8'h04;
    localparam logic [7:0] CLR_AWARD_3 = 8'h09;
    localparam logic [7:0] CLR_AWARD_4 = 8'h16;

    // Map a line count to its BCD award; counts outside 1..4 score nothing.
    function automatic logic [7:0] clr_award(input logic [2:0] lines);
        case (lines)
            3'd1:    return CLR_AWARD_1;
            3'd2:    return CLR_AWARD_2;
            3'd3:    return CLR_AWARD_3;
            3'd4:    return CLR_AWARD_4;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/score_bcd_digit_add.sv
// Single-digit BCD adder with carry; purely combinational.
module score_bcd_digit_add
    import score_pkg::*;
(
    input  bcd_digit_t a,
    input  bcd_digit_t b,
    input  logic       cin,
    output bcd_digit_t sum,
    output logic       cout
);

    logic [4:0] t;

    // Binary sum first; anything above 9 is corrected by adding 6.
    assign t    = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    assign cout = (t > 5'd9);
    assign sum  = cout ? (t[3:0] + 4'd6) : t[3:0];

endmodule

// File: rtl/score_add_sequencer.sv
// Digit-serial BCD score controller: arbitrates two award sources and walks one
// shared BCD digit adder across the score, LSD first, then commits the result.
module score_add_sequencer
    import score_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr_valid,
    input  logic [2:0]              clr_lines,
    output logic                    clr_ready,
    input  logic                    drop_valid,
    input  logic [7:0]              drop_pts,
    output logic                    drop_ready,
    input  logic                    score_clear,
    output logic [4*NUM_DIGITS-1:0] score,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow
);

    localparam int             W         = 4 * NUM_DIGITS;
    localparam logic [2:0]     LAST_IDX  = 3'(NUM_DIGITS - 1);
    localparam logic [W-1:0]   ALL_NINES = {NUM_DIGITS{4'h9}};

    state_t         state_q, state_d;
    logic [2:0]     idx_q, idx_d;
    logic           carry_q, carry_d;
    logic [7:0]     addend_q, addend_d;
    logic [W-1:0]   work_q, work_d;
    logic [W-1:0]   score_q, score_d;
    logic           ovf_q, ovf_d;
    logic           rr_q, rr_d;

    logic           grant_clr;
    logic           grant_drop;
    bcd_digit_t     dig_sum;
    logic           dig_cout;
    logic [W-1:0]   work_shifted;

    // The one adder: current LSD of the work register plus current addend digit.
    score_bcd_digit_add u_digit_add (
        .a    (work_q[3:0]),
        .b    (addend_q[3:0]),
        .cin  (carry_q),
        .sum  (dig_sum),
        .cout (dig_cout)
    );

    // New digit enters at the top so after NUM_DIGITS shifts the order is restored.
    assign work_shifted = {dig_sum, work_q[W-1:4]};

    // Round-robin grant; only offered in IDLE and never during a clear.
    always_comb begin
        grant_clr  = 1'b0;
        grant_drop = 1'b0;
        if (state_q == ST_IDLE && !score_clear) begin
            grant_clr  = clr_valid  && (!drop_valid || rr_q == RR_CLR);
            grant_drop = drop_valid && (!clr_valid  || rr_q == RR_DROP);
        end
    end

    assign clr_ready  = grant_clr;
    assign drop_ready = grant_drop;

    // Next-state logic; score_clear overrides everything else.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        addend_d = addend_q;
        work_d   = work_q;
        score_d  = score_q;
        ovf_d    = ovf_q;
        rr_d     = rr_q;
        if (score_clear) begin
            state_d = ST_IDLE;
            score_d = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_clr || grant_drop) begin
                        addend_d = grant_clr ? clr_award(clr_lines) : drop_pts;
                        work_d   = score_q;
                        idx_d    = '0;
                        carry_d  = 1'b0;
                        rr_d     = grant_clr ? RR_DROP : RR_CLR;
                        state_d  = ST_ADD;
                    end
                end
                ST_ADD: begin
                    work_d   = work_shifted;
                    addend_d = {4'h0, addend_q[7:4]};
                    carry_d  = dig_cout;
                    idx_d    = idx_q + 3'd1;
                    if (idx_q == LAST_IDX) begin
                        // Score is loaded on entry to COMMIT so it and done are visible together.
                        state_d = ST_COMMIT;
                        if (dig_cout) begin
                            score_d = ALL_NINES;
                            ovf_d   = 1'b1;
                        end else begin
                            score_d = work_shifted;
                        end
                    end
                end
                ST_COMMIT: state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            addend_q <= '0;
            work_q   <= '0;
            score_q  <= '0;
            ovf_q    <= 1'b0;
            rr_q     <= RR_CLR;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            addend_q <= addend_d;
            work_q   <= work_d;
            score_q  <= score_d;
            ovf_q    <= ovf_d;
            rr_q     <= rr_d;
        end
    end

    assign score    = score_q;
    assign overflow = ovf_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_COMMIT);

endmodule

// File: tb/tb_score_add_sequencer.sv
// Directed bench for score_add_sequencer with hand-computed expectations.
module tb_score_add_sequencer;

    localparam int ND = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr_valid;
    logic [2:0]  clr_lines;
    logic        clr_ready;
    logic        drop_valid;
    logic [7:0]  drop_pts;
    logic        drop_ready;
    logic        score_clear;
    logic [15:0] score;
    logic        busy;
    logic        done;
    logic        overflow;

    int errors = 0;
    int checks = 0;

    score_add_sequencer #(.NUM_DIGITS(ND)) dut (
        .clk         (clk),
        .rst         (rst),
        .clr_valid   (clr_valid),
        .clr_lines   (clr_lines),
        .clr_ready   (clr_ready),
        .drop_valid  (drop_valid),
        .drop_pts    (drop_pts),
        .drop_ready  (drop_ready),
        .score_clear (score_clear),
        .score       (score),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    // Single checking point: count, compare, report.
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request and hold it until accepted; returns one cycle after acceptance.
    task automatic req(input bit is_clr, input logic [2:0] lines, input logic [7:0] pts);
        int n;
        n = 0;
        if (is_clr) begin clr_lines = lines; clr_valid = 1'b1; end
        else        begin drop_pts  = pts;   drop_valid = 1'b1; end
        #1;
        while (((is_clr ? clr_ready : drop_ready) !== 1'b1) && n < 40) begin
            @(posedge clk);
            #2;
            n++;
        end
        check_val(is_clr ? "clr_accept" : "drop_accept", is_clr ? clr_ready : drop_ready, 1);
        @(posedge clk);
        #1;
        if (is_clr) clr_valid = 1'b0;
        else        drop_valid = 1'b0;
    endtask

    // Wait (bounded) for done; latency counted from the first ADD cycle.
    task automatic wait_done(input string tag, input int exp_lat);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_val(tag, n, exp_lat);
    endtask

    task automatic award(input bit is_clr, input logic [2:0] lines, input logic [7:0] pts);
        req(is_clr, lines, pts);
        wait_done("done_latency", ND);
        tick();
    endtask

    task automatic pulse_clear();
        score_clear = 1'b1;
        tick();
        score_clear = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        int  nc;
        int  nd;
        bit  got_clr;
        bit  seen_done;

        rst = 1'b1;
        clr_valid = 1'b0; clr_lines = 3'd0;
        drop_valid = 1'b0; drop_pts = 8'h00;
        score_clear = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state.
        check_val("rst_score", score, 16'h0000);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_overflow", overflow, 0);

        // Four lines cleared: ready in cycle 0, done at cycle 5.
        clr_lines = 3'd4; clr_valid = 1'b1;
        #1;
        check_val("t1_clr_ready_c0", clr_ready, 1);
        check_val("t1_drop_ready_c0", drop_ready, 0);
        @(posedge clk); #1;
        clr_valid = 1'b0;
        check_val("t1_busy_c1", busy, 1);
        check_val("t1_ready_in_add", clr_ready, 0);
        repeat (ND - 1) tick();
        check_val("t1_no_done_c4", done, 0);
        check_val("t1_score_hidden_c4", score, 16'h0000);
        tick();
        check_val("t1_done_c5", done, 1);
        check_val("t1_score", score, 16'h0016);
        tick();
        check_val("t1_done_pulse_end", done, 0);
        check_val("t1_idle", busy, 0);

        // Carry chain across two digits.
        pulse_clear();
        check_val("t2_cleared", score, 16'h0000);
        award(1'b0, 3'd0, 8'h95);
        check_val("t2_score_95", score, 16'h0095);
        award(1'b0, 3'd0, 8'h07);
        check_val("t2_score_102", score, 16'h0102);

        // Both requesters held: grants alternate starting with clr.
        pulse_clear();
        clr_lines = 3'd2; drop_pts = 8'h11;
        clr_valid = 1'b1; drop_valid = 1'b1;
        nc = 0; nd = 0;
        for (int g = 0; g < 6; g++) begin
            n = 0;
            #1;
            while (clr_ready !== 1'b1 && drop_ready !== 1'b1 && n < 40) begin
                @(posedge clk); #2; n++;
            end
            got_clr = clr_ready;
            check_val("t3_grant_is_clr", clr_ready, (g % 2 == 0) ? 1 : 0);
            check_val("t3_grant_drop", drop_ready, (g % 2 == 0) ? 0 : 1);
            @(posedge clk); #1;
            if (got_clr) begin nc++; if (nc == 3) clr_valid = 1'b0; end
            else         begin nd++; if (nd == 3) drop_valid = 1'b0; end
            wait_done("t3_latency", ND);
            tick();
        end
        check_val("t3_total", score, 16'h0045);

        // Build 9990, then saturate.
        pulse_clear();
        for (int k = 0; k < 100; k++) award(1'b0, 3'd0, 8'h99);
        award(1'b0, 3'd0, 8'h90);
        check_val("t4_score_9990", score, 16'h9990);
        check_val("t4_no_ovf_yet", overflow, 0);
        award(1'b1, 3'd4, 8'h00);
        check_val("t4_sat_score", score, 16'h9999);
        check_val("t4_ovf_set", overflow, 1);
        award(1'b0, 3'd0, 8'h01);
        check_val("t4_sat_again", score, 16'h9999);
        check_val("t4_ovf_sticky", overflow, 1);
        drop_pts = 8'h01; drop_valid = 1'b1; score_clear = 1'b1;
        #1;
        check_val("t4_ready_in_clear", drop_ready, 0);
        @(posedge clk); #1;
        score_clear = 1'b0; drop_valid = 1'b0;
        check_val("t4_clear_score", score, 16'h0000);
        check_val("t4_clear_ovf", overflow, 0);

        // Clear during ADD digit 2 discards the award.
        award(1'b0, 3'd0, 8'h25);
        check_val("t5_score_25", score, 16'h0025);
        req(1'b1, 3'd3, 8'h00);
        tick();
        tick();
        score_clear = 1'b1;
        #1;
        check_val("t5_busy_before_clear", busy, 1);
        @(posedge clk); #1;
        score_clear = 1'b0;
        check_val("t5_idle_after_clear", busy, 0);
        check_val("t5_score_zeroed", score, 16'h0000);
        seen_done = 1'b0;
        for (int k = 0; k < ND + 2; k++) begin
            if (done === 1'b1) seen_done = 1'b1;
            tick();
        end
        check_val("t5_no_done", seen_done, 0);
        award(1'b0, 3'd0, 8'h33);
        check_val("t5_new_award", score, 16'h0033);

        // Asynchronous reset mid-ADD.
        req(1'b1, 3'd4, 8'h00);
        tick();
        #3 rst = 1'b1;
        #1;
        check_val("t6_rst_score", score, 16'h0000);
        check_val("t6_rst_busy", busy, 0);
        check_val("t6_rst_done", done, 0);
        check_val("t6_rst_ovf", overflow, 0);
        #7 rst = 1'b0;
        @(posedge clk); #1;
        // Pointer was left on drop; reset must return it to clr.
        clr_lines = 3'd0; clr_valid = 1'b1;
        drop_pts = 8'h05; drop_valid = 1'b1;
        #1;
        check_val("t6_rr_clr_first", clr_ready, 1);
        check_val("t6_rr_drop_wait", drop_ready, 0);
        @(posedge clk); #1;
        clr_valid = 1'b0; drop_valid = 1'b0;
        wait_done("t6_zero_award_done", ND);
        check_val("t6_score_unchanged", score, 16'h0000);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
